// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared architectural definitions for the execution domain's
//               register bank (g0-g15, fp, sp) and its write requests.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Architectural register indices
    localparam int REG_G0    = 0;
    localparam int REG_G1    = 1;
    localparam int REG_G2    = 2;
    localparam int REG_G3    = 3;
    localparam int REG_G4    = 4;
    localparam int REG_G5    = 5;
    localparam int REG_G6    = 6;
    localparam int REG_G7    = 7;
    localparam int REG_G8    = 8;
    localparam int REG_G9    = 9;
    localparam int REG_G10   = 10;
    localparam int REG_G11   = 11;
    localparam int REG_G12   = 12;
    localparam int REG_G13   = 13;
    localparam int REG_G14   = 14;
    localparam int REG_G15   = 15;
    localparam int REG_FP    = 16;
    localparam int REG_SP    = 17;
    localparam int NREG_ARCH = 18;

    typedef logic [4:0]  regidx_t;
    typedef logic [63:0] regval_t;

    typedef struct packed {
        regidx_t idx;
        regval_t data;
    } wr_req_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/regwr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans the valid vector
//               starting at ptr (wrapping mod N) and returns the first set
//               entry as a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W:0] w_pos;

    // Walk offsets from far to near so the nearest valid entry is assigned last
    always_comb begin
        w_pos = '0;
        idx   = '0;
        grant = '0;
        any   = |valid;
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (w_pos >= (PTR_W + 1)'(N)) begin
                w_pos = w_pos - (PTR_W + 1)'(N);
            end
            if (valid[w_pos[PTR_W-1:0]]) begin
                idx = w_pos[PTR_W-1:0];
            end
        end
        grant[idx] = any;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/regwr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regwr_arbiter
// Description : Round-robin write-port arbiter for the register bank. Grants
//               one of NREQ producers per cycle, drives a registered write
//               port and flags out-of-range indices as a sticky error.
//               Optional build macro REGWR_ARB_STATS_EN adds per-requester
//               16-bit saturating grant counters.
// Revision    : 1.0 - initial release
// ============================================================================
module regwr_arbiter
    import cpu_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = $bits(regval_t),
    parameter int IDX_W  = $bits(regidx_t),
    parameter int NREG   = NREG_ARCH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    freeze,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*IDX_W-1:0]   req_idx,
    input  logic [NREQ*DATA_W-1:0]  req_data,
    output logic                    wr_en,
    output logic [IDX_W-1:0]        wr_idx,
    output logic [DATA_W-1:0]       wr_data,
    output logic                    err_flag,
    output logic [IDX_W-1:0]        err_idx,
    input  logic                    err_clr
`ifdef REGWR_ARB_STATS_EN
    ,
    input  logic [$clog2(NREQ)-1:0] stat_sel,
    output logic [15:0]             stat_count,
    input  logic                    stat_clr
`endif
);

    localparam int c_PTR_W = $clog2(NREQ);

    logic [c_PTR_W-1:0] r_rr_ptr;
    logic [NREQ-1:0]    w_onehot;
    logic [c_PTR_W-1:0] w_win;
    logic               w_any;
    logic               w_grant;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_in_range;
    logic               w_new_err;
    logic [c_PTR_W-1:0] w_ptr_nxt;

    rr_pick #(
        .N     (NREQ),
        .PTR_W (c_PTR_W)
    ) u_pick (
        .valid (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_onehot),
        .idx   (w_win),
        .any   (w_any)
    );

    // Grant qualification and winner payload selection
    always_comb begin
        w_grant    = w_any & ~freeze & reset;
        req_ready  = w_grant ? w_onehot : '0;
        w_sel_idx  = req_idx[w_win*IDX_W +: IDX_W];
        w_sel_data = req_data[w_win*DATA_W +: DATA_W];
        w_in_range = (w_sel_idx < IDX_W'(NREG));
        w_new_err  = w_grant & ~w_in_range;
        w_ptr_nxt  = (w_win == c_PTR_W'(NREQ - 1)) ? '0 : w_win + c_PTR_W'(1);
    end

    // Round-robin pointer advances past the winner on every grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= '0;
        end else if (w_grant) begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    // Registered write port; index/data hold while no write is issued
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en   <= 1'b0;
            wr_idx  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= w_grant & w_in_range;
            if (w_grant && w_in_range) begin
                wr_idx  <= w_sel_idx;
                wr_data <= w_sel_data;
            end
        end
    end

    // Sticky error: first bad index wins, but a new error beats a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_flag <= 1'b0;
            err_idx  <= '0;
        end else if (w_new_err) begin
            err_flag <= 1'b1;
            if (!err_flag || err_clr) begin
                err_idx <= w_sel_idx;
            end
        end else if (err_clr) begin
            err_flag <= 1'b0;
            err_idx  <= '0;
        end
    end

`ifdef REGWR_ARB_STATS_EN
    logic [15:0] r_stat_cnt [NREQ];

    // Saturating per-requester grant counters; a clear drops same-cycle grants
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_stat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stat_clr) begin
                    r_stat_cnt[i] <= '0;
                end else if (req_ready[i] && (r_stat_cnt[i] != 16'hFFFF)) begin
                    r_stat_cnt[i] <= r_stat_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign stat_count = r_stat_cnt[stat_sel];
`endif

endmodule : regwr_arbiter
`default_nettype wire

// File: doc/regwr_arbiter.md
Name: regwr_arbiter

Overview:
Write-port arbiter for the execution domain's register bank (g0–g15, fp, sp).
- Accepts register write requests from NREQ producers (ALU writeback, load unit, stack/call unit, spare) over per-requester valid/ready handshakes.
- Grants at most one per cycle, round-robin.
- Drives a single registered write port into the register bank.
- Sits between the producers and the register bank. Rejects out-of-range register indices and records them as a sticky error.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 64, register data width
IDX_W, 5, register index width
NREG, 18, number of valid registers: 0–15 = g0–g15, 16 = fp, 17 = sp

Ports:
clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
freeze  in  1  when 1: no grants issued, round-robin pointer holds
req_valid  in  NREQ  per-requester write request valid
req_ready  out  NREQ  per-requester grant; transfer when valid&ready
req_idx  in  NREQ*IDX_W  packed target indices, requester i at [i*IDX_W +: IDX_W]
req_data  in  NREQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
wr_en  out  1  register-bank write strobe
wr_idx  out  IDX_W  register-bank write index
wr_data  out  DATA_W  register-bank write data
err_flag  out  1  sticky: out-of-range index accepted
err_idx  out  IDX_W  index of first out-of-range request since last clear
err_clr  in  1  clears err_flag/err_idx

Behaviour:
Reset (reset==0, async): rr_ptr=0, wr_en=0, wr_idx=0, wr_data=0, err_flag=0, err_idx=0.

Grant logic (combinational):
- Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod NREQ.
- req_ready is one-hot of the winner, or all-zero if freeze=1, no valid request, or reset asserted.
- req_ready never depends on req_idx/req_data.

Requester rules:
- Once req_valid is raised, req_valid/idx/data stay stable until ready.
- The bench flags any violation as a requester error; the arbiter needs no checking logic for it.

Pointer update:
- On a grant, rr_ptr <= winner+1, wrapping NREQ-1 -> 0.
- With no grant, rr_ptr holds.

Write port (1-cycle latency, registered):
- In-range grant (idx < NREG): next cycle wr_en=1, wr_idx/wr_data = winner's payload.
- Otherwise wr_en=0. wr_idx/wr_data hold their last values when wr_en=0.

Out-of-range grant (idx >= NREG):
- Request is still accepted (ready=1); no write issued.
- Next cycle err_flag=1.
- err_idx latched only if err_flag was 0 (first error wins).

err_clr:
- err_clr=1 clears err_flag/err_idx next cycle.
- Same-cycle err_clr and new error: the new error wins (err_flag=1, err_idx=new idx).

freeze:
- Asserted mid-stream: blocks grants that cycle.
- A write already registered still completes next cycle.

Reset mid-operation:
- Pending requests are dropped.
- An in-flight write whose wr_en would assert after reset does not occur.

Throughput: one write per cycle sustained; each valid requester served within NREQ grants.

Optional Feature:
REGWR_ARB_STATS_EN
- Defined: adds NREQ 16-bit saturating grant counters (stop at 0xFFFF), zeroed by reset, incremented on each grant to that requester.
  - Extra ports: stat_sel (in, clog2(NREQ)) and stat_count (out, 16), combinational read of counter[stat_sel].
  - stat_clr (in, 1) zeroes all counters next cycle; a same-cycle grant is not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package (cpu_pkg):
  - REG_G0..REG_G15, REG_FP=16, REG_SP=17, NREG_ARCH=18
  - regidx_t (logic [4:0]), regval_t (logic [63:0])
  - wr_req_t struct {idx, data}
- One sub-module: rr_pick (parameter N). Inputs: valid vector, pointer. Outputs: one-hot grant, winner index, any. Purely combinational, reused later for read-port arbitration.

Test Plan:
- Reset then single request: req_valid[1]=1, idx=3, data=0xDEAD -> ready[1] same cycle; next cycle wr_en=1, wr_idx=3, wr_data=0xDEAD; rr_ptr=2.
- All four valid continuously with rr_ptr=0 -> grants in order 0,1,2,3,0,…, one per cycle, wr_en high every cycle after the first.
- Out-of-range idx=20 from req 2, then idx=25 from req 0 -> no wr_en; err_flag=1, err_idx=20 after both. Then err_clr=1 same cycle as idx=30 -> err_flag=1, err_idx=30.
- freeze=1 with req 0 and 3 valid -> no ready for 5 cycles, rr_ptr unchanged. freeze=0 -> req 0 granted first, then 3.
- Boundary indices: idx=17 (sp) -> written; idx=18 -> rejected and flagged.
- reset pulsed low the cycle a grant occurs -> no wr_en afterwards, all outputs 0. With REGWR_ARB_STATS_EN: 70000 grants to req 1 -> stat_count=0xFFFF.
